reg_universal: RTL and testbench
================================

Name: reg_universal

Overview:
- Parametrised successor to the single-bit synchronous clear/enable flip-flop.
- WIDTH-bit register with synchronous clear, clock enable, and an operation select:
  - hold, parallel load, logical shift left/right with serial input, rotate left/right, increment, decrement.
- Registered carry/shift-out and zero flags.
- Used as the general-purpose storage/shift/count element in lab datapaths (serializers, counters, accumulators).

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RST_VAL, 0, value loaded into q on clr (WIDTH bits; upper bits ignored if wider).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  reset: synchronous, active-high; dominates every other input.
- ena  input  1  clock enable; when 0, all state holds (op ignored).
- op  input  3  operation select (op_t, see Decomposition).
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input for SHL (enters bit 0) and SHR (enters bit WIDTH-1).
- q  output  WIDTH  register contents.
- cout  output  1  registered carry/borrow/shifted-out bit of the last executed op.
- zero  output  1  combinational: q == 0.

Behaviour:
- Reset:
  - clr=1 at a rising edge -> q=RST_VAL, cout=0, regardless of ena/op.
  - zero follows q.
  - Before the first clr, q/cout are X; the bench must clr first.
- ena=0 (and clr=0): q and cout hold.
- ena=1, clr=0: one-cycle latency; the result is visible after the edge.
- Operation table:
  - HOLD (000): q, cout unchanged.
  - LOAD (001): q<=d; cout<=0.
  - SHL (010): q<={q[W-2:0],sin}; cout<=q[W-1].
  - SHR (011): q<={sin,q[W-1:1]}; cout<=q[0].
  - ROL (100): q<={q[W-2:0],q[W-1]}; cout<=q[W-1].
  - ROR (101): q<={q[0],q[W-1:1]}; cout<=q[0].
  - INC (110): {cout,q}<=q+1 in W+1 bits.
    - Wrap at all-ones -> q=0, cout=1.
    - Otherwise cout=0.
  - DEC (111): q<=q-1 modulo 2^W.
    - cout=1 only when q was 0 (borrow); q becomes all-ones.
    - Otherwise cout=0.
- Arithmetic is unsigned, modulo 2^WIDTH; no saturation.
- Simultaneous events:
  - clr beats ena and op.
  - ena=0 beats op.
  - sin is sampled only on SHL/SHR.
- Reset mid-operation (e.g. during a shift sequence or count): the next edge with clr=1 restores RST_VAL; the interrupted sequence is not resumed.
- No internal FSM beyond the register state; every edge is independent given (clr, ena, op, d, sin, q).

Decomposition:
- Package reg_universal_pkg:
  - typedef enum logic [2:0] op_t {OP_HOLD, OP_LOAD, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_INC, OP_DEC} with the encodings above.
  - Localparam list of op names for bench printing.
- Top reg_universal:
  - Computes next-state value and next cout combinationally in one always_comb case on op.
  - Registers them in one always_ff with clr/ena priority.
- Optional sub-module reg_bit_cell:
  - Per-bit 1-bit register with sync clr (to its RST_VAL bit) and ena.
  - Instantiated WIDTH times by a generate loop.
  - Keeps the flip-flop primitive reusable.

Test Plan (WIDTH=8, RST_VAL=8'h00 unless noted):
- clr=1, ena=0, op=LOAD, d=8'hFF for one edge -> q=00, cout=0, zero=1.
- clr=0, ena=1, op=LOAD, d=8'hA5 -> q=A5, cout=0. Then ena=0, op=INC for 3 edges -> q stays A5.
- q=8'h81, op=SHL, sin=0 -> q=02, cout=1. Then op=SHR, sin=1 -> q=81, cout=0. Then op=ROR -> q=C0, cout=1. Then op=ROL -> q=81, cout=1.
- LOAD 8'hFE, then INC x2 -> q=FF cout=0, then q=00 cout=1 zero=1. Then DEC -> q=FF, cout=1. Then DEC -> q=FE, cout=0.
- Serializer: LOAD 8'h96, then 8 SHL edges with sin=0 -> cout sequence 1,0,0,1,0,1,1,0; final q=00, zero=1.
- Reset priority: RST_VAL=8'h3C, q=8'h11, assert clr together with ena=1, op=INC in mid-count -> q=3C, cout=0. Deassert clr, INC -> q=3D.

Source files
------------

// File: rtl/reg_universal_pkg.sv
// Shared types for the universal register: op encodings and printable op names.
package reg_universal_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_INC  = 3'b110,
    OP_DEC  = 3'b111
  } op_t;

  // Four ASCII chars per entry, indexed by op encoding
  localparam logic [0:7][31:0] OP_NAME = '{
    "HOLD", "LOAD", " SHL", " SHR", " ROL", " ROR", " INC", " DEC"
  };

  function automatic logic [31:0] op_name(input op_t o);
    return OP_NAME[o];
  endfunction

endpackage

// File: rtl/reg_universal_if.sv
// Control/data bundle for reg_universal; the datapath owner drives the master side.
interface reg_universal_if
  import reg_universal_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             ena;
  op_t              op;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             cout;
  logic             zero;

  modport master (output ena, op, d, sin, input  q, cout, zero);
  modport slave  (input  ena, op, d, sin, output q, cout, zero);
endinterface

// File: rtl/reg_universal_bit_cell.sv
// One storage bit with synchronous clear to its own reset value and a clock enable.
module reg_bit_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic ena,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (clr)      q <= RST_BIT;
    else if (ena) q <= d;
  end
endmodule

// File: rtl/reg_universal.sv
// WIDTH-bit register with load/shift/rotate/count ops, registered carry-out, zero flag.
module reg_universal
  import reg_universal_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter logic [63:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            clr,
  reg_universal_if.slave  bus
);
  logic [WIDTH-1:0] q, nq;
  logic             cout_r, nc;

  always_comb begin
    nq = q;
    nc = cout_r;
    case (bus.op)
      OP_HOLD: ;
      OP_LOAD: begin nq = bus.d;                    nc = 1'b0;       end
      OP_SHL:  begin nq = {q[WIDTH-2:0], bus.sin};  nc = q[WIDTH-1]; end
      OP_SHR:  begin nq = {bus.sin, q[WIDTH-1:1]};  nc = q[0];       end
      OP_ROL:  begin nq = {q[WIDTH-2:0], q[WIDTH-1]}; nc = q[WIDTH-1]; end
      OP_ROR:  begin nq = {q[0], q[WIDTH-1:1]};     nc = q[0];       end
      // Carry falls out of the extra top bit of a WIDTH+1 add
      OP_INC:  {nc, nq} = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
      OP_DEC:  begin
        nq = q - {{(WIDTH-1){1'b0}}, 1'b1};
        nc = (q == '0);
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg_bit_cell #(.RST_BIT(RST_VAL[i])) u_cell (
      .clk (clk),
      .clr (clr),
      .ena (bus.ena),
      .d   (nq[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (clr)          cout_r <= 1'b0;
    else if (bus.ena) cout_r <= nc;
  end

  assign bus.q    = q;
  assign bus.cout = cout_r;
  assign bus.zero = (q == '0);

endmodule

// File: tb/tb_reg_universal.sv
// Directed bench for reg_universal: one DUT with RST_VAL=0, one with RST_VAL=8'h3C.
module tb_reg_universal;
  import reg_universal_pkg::*;

  logic clk = 1'b0;
  logic clr0, clr1;
  int   ncmp  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  reg_universal_if #(.WIDTH(8)) bus0 ();
  reg_universal_if #(.WIDTH(8)) bus1 ();

  reg_universal #(.WIDTH(8), .RST_VAL(64'h00)) dut0 (.clk(clk), .clr(clr0), .bus(bus0));
  reg_universal #(.WIDTH(8), .RST_VAL(64'h3C)) dut1 (.clk(clk), .clr(clr1), .bus(bus1));

  task automatic step0(input logic c, input logic e, input op_t o, input logic [7:0] dd, input logic s);
    clr0 = c; bus0.ena = e; bus0.op = o; bus0.d = dd; bus0.sin = s;
    @(posedge clk); #1;
  endtask

  task automatic step1(input logic c, input logic e, input op_t o, input logic [7:0] dd);
    clr1 = c; bus1.ena = e; bus1.op = o; bus1.d = dd; bus1.sin = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input op_t o,
                     input logic [7:0] gq, input logic gc, input logic gz,
                     input logic [7:0] eq, input logic ec, input logic ez);
    ncmp++;
    assert (gq === eq) else begin
      nfail++; $error("FAIL %s [%s] q: got %h want %h", tag, op_name(o), gq, eq);
    end
    ncmp++;
    assert (gc === ec) else begin
      nfail++; $error("FAIL %s [%s] cout: got %b want %b", tag, op_name(o), gc, ec);
    end
    ncmp++;
    assert (gz === ez) else begin
      nfail++; $error("FAIL %s [%s] zero: got %b want %b", tag, op_name(o), gz, ez);
    end
  endtask

  `define C0(t, eq, ec, ez) chk(t, bus0.op, bus0.q, bus0.cout, bus0.zero, eq, ec, ez)
  `define C1(t, eq, ec, ez) chk(t, bus1.op, bus1.q, bus1.cout, bus1.zero, eq, ec, ez)

  initial begin
    logic [7:0] pat;
    logic [7:0] exq;
    clr0 = 1'b0; clr1 = 1'b0;
    bus0.ena = 1'b0; bus0.op = OP_HOLD; bus0.d = '0; bus0.sin = 1'b0;
    bus1.ena = 1'b0; bus1.op = OP_HOLD; bus1.d = '0; bus1.sin = 1'b0;
    #2;

    // reset dominates ena=0 and a pending LOAD
    step0(1, 0, OP_LOAD, 8'hFF, 0);  `C0("reset",      8'h00, 0, 1);
    step0(0, 1, OP_LOAD, 8'hA5, 0);  `C0("load_a5",    8'hA5, 0, 0);
    step0(0, 0, OP_INC,  8'h00, 0);  `C0("ena0_inc_1", 8'hA5, 0, 0);
    step0(0, 0, OP_INC,  8'h00, 0);  `C0("ena0_inc_2", 8'hA5, 0, 0);
    step0(0, 0, OP_INC,  8'h00, 0);  `C0("ena0_inc_3", 8'hA5, 0, 0);

    // shift / rotate
    step0(0, 1, OP_LOAD, 8'h81, 0);  `C0("load_81",    8'h81, 0, 0);
    step0(0, 1, OP_SHL,  8'h00, 0);  `C0("shl",        8'h02, 1, 0);
    step0(0, 1, OP_SHR,  8'h00, 1);  `C0("shr_sin1",   8'h81, 0, 0);
    step0(0, 1, OP_ROR,  8'h00, 0);  `C0("ror",        8'hC0, 1, 0);
    step0(0, 1, OP_ROL,  8'h00, 0);  `C0("rol",        8'h81, 1, 0);

    // count wrap in both directions, with HOLD keeping the carry
    step0(0, 1, OP_LOAD, 8'hFE, 0);  `C0("load_fe",    8'hFE, 0, 0);
    step0(0, 1, OP_INC,  8'h00, 0);  `C0("inc_ff",     8'hFF, 0, 0);
    step0(0, 1, OP_INC,  8'h00, 0);  `C0("inc_wrap",   8'h00, 1, 1);
    step0(0, 1, OP_HOLD, 8'h55, 1);  `C0("hold",       8'h00, 1, 1);
    step0(0, 1, OP_DEC,  8'h00, 0);  `C0("dec_borrow", 8'hFF, 1, 0);
    step0(0, 1, OP_DEC,  8'h00, 0);  `C0("dec_fe",     8'hFE, 0, 0);

    // serializer: 8'h96 shifted out MSB first
    pat = 8'h96;
    step0(0, 1, OP_LOAD, pat, 0);    `C0("load_96",    8'h96, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step0(0, 1, OP_SHL, 8'h00, 0);
      exq = pat << (k + 1);
      `C0($sformatf("ser_%0d", k), exq, pat[7-k], exq == 8'h00);
    end

    // non-zero reset value, clear wins over a mid-count INC
    step1(1, 0, OP_HOLD, 8'h00);     `C1("r1_reset",   8'h3C, 0, 0);
    step1(0, 1, OP_LOAD, 8'h10);     `C1("r1_load",    8'h10, 0, 0);
    step1(0, 1, OP_INC,  8'h00);     `C1("r1_inc",     8'h11, 0, 0);
    step1(1, 1, OP_INC,  8'h00);     `C1("r1_clr_inc", 8'h3C, 0, 0);
    step1(0, 1, OP_INC,  8'h00);     `C1("r1_inc_3d",  8'h3D, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
